// File: rtl/fme_pkg.sv
// Shared types and the neighbour offset table for the fractional-ME search controller.
// Offsets are signed quarter-pel units.
package fme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EVAL,
        DONE
    } fme_st_e;

    typedef enum logic {
        HALF,
        QUART
    } fme_phase_e;

    localparam int NUM_CAND = 17;
    localparam int NUM_NB   = 8;

    // Neighbour table, raster order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
    function automatic logic signed [2:0] nb_dx(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3, 3'd5: return -3'sd1;
            3'd2, 3'd4, 3'd7: return 3'sd1;
            default:          return 3'sd0;
        endcase
    endfunction

    function automatic logic signed [2:0] nb_dy(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return -3'sd1;
            3'd5, 3'd6, 3'd7: return 3'sd1;
            default:          return 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/fme_sad_acc.sv
// Saturating SAD accumulator: clear has priority over add; result clamps at all-ones.
module fme_sad_acc #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [SAD_W-1:0] o_sad
);

    logic [SAD_W-1:0] r_acc;

    function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [SAD_W:0] sum;
        sum = {1'b0, a} + (SAD_W+1)'(b);
        return sum[SAD_W] ? {SAD_W{1'b1}} : sum[SAD_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= sat_add(r_acc, i_din);
        end
    end

    assign o_sad = r_acc;

endmodule

// File: rtl/fme_search_ctrl.sv
// Fractional motion-estimation search sequencer: 9 half-pel then 8 quarter-pel candidates,
// each scanned in raster order into the interpolation datapath, best SAD kept.
module fme_search_ctrl
    import fme_pkg::*;
#(
    parameter int BLK_W  = 8,
    parameter int BLK_H  = 8,
    parameter int PIX_W  = 8,
    parameter int SAD_W  = 16,
    parameter int DP_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic signed [2:0]       best_dx,
    output logic signed [2:0]       best_dy,
    output logic        [SAD_W-1:0] best_sad,
    output logic signed [2:0]       cand_dx,
    output logic signed [2:0]       cand_dy,
    output logic        [7:0]       pix_pos,
    output logic                    pix_valid,
    input  logic        [PIX_W-1:0] absdiff,
    input  logic                    absdiff_valid
);

    localparam int LAT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [3:0]       COL_MAX = 4'(BLK_W - 1);
    localparam logic [3:0]       ROW_MAX = 4'(BLK_H - 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(DP_LAT - 1);

    fme_st_e           r_st;
    fme_phase_e        r_phase;
    logic [3:0]        r_k;
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [LAT_W-1:0]  r_lat;
    logic              r_busy;
    logic              r_done;
    logic              r_pix_valid;
    logic signed [2:0] r_cand_dx;
    logic signed [2:0] r_cand_dy;
    logic signed [2:0] r_half_dx;
    logic signed [2:0] r_half_dy;
    logic signed [2:0] r_best_dx;
    logic signed [2:0] r_best_dy;
    logic [SAD_W-1:0]  r_best_sad;

    logic [SAD_W-1:0]  w_sad;
    logic              w_acc_en;
    logic              w_acc_clr;
    logic              w_take;
    logic              w_last_pix;
    logic signed [2:0] w_nbx;
    logic signed [2:0] w_nby;
    logic [2:0]        w_nb_next;

    // Returned abs-diffs may still be in flight during DRAIN; EVAL consumes and clears.
    assign w_acc_en  = absdiff_valid && ((r_st == SCAN) || (r_st == DRAIN));
    assign w_acc_clr = (r_st == EVAL) || ((r_st == IDLE) && start);

    fme_sad_acc #(
        .PIX_W (PIX_W),
        .SAD_W (SAD_W)
    ) u_sad_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_acc_clr),
        .i_en  (w_acc_en),
        .i_din (absdiff),
        .o_sad (w_sad)
    );

    // Very first candidate always loads; afterwards strict less-than so ties keep the earlier one.
    assign w_take     = ((r_phase == HALF) && (r_k == 4'd0)) || (w_sad < r_best_sad);
    assign w_nbx      = w_take ? r_cand_dx : r_best_dx;
    assign w_nby      = w_take ? r_cand_dy : r_best_dy;
    assign w_last_pix = (r_row == ROW_MAX) && (r_col == COL_MAX);
    assign w_nb_next  = r_k[2:0] + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= IDLE;
            r_phase     <= HALF;
            r_k         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_lat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_valid <= 1'b0;
            r_cand_dx   <= '0;
            r_cand_dy   <= '0;
            r_half_dx   <= '0;
            r_half_dy   <= '0;
            r_best_dx   <= '0;
            r_best_dy   <= '0;
            r_best_sad  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_st)
                IDLE: begin
                    if (start) begin
                        r_st        <= SCAN;
                        r_busy      <= 1'b1;
                        r_phase     <= HALF;
                        r_k         <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_cand_dx   <= '0;
                        r_cand_dy   <= '0;
                        r_pix_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_last_pix) begin
                        r_st        <= DRAIN;
                        r_pix_valid <= 1'b0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_lat       <= '0;
                    end else if (r_col == COL_MAX) begin
                        r_col <= '0;
                        r_row <= r_row + 4'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                DRAIN: begin
                    if (r_lat == LAT_MAX) begin
                        r_st <= EVAL;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                EVAL: begin
                    if (w_take) begin
                        r_best_dx  <= r_cand_dx;
                        r_best_dy  <= r_cand_dy;
                        r_best_sad <= w_sad;
                    end
                    if ((r_phase == QUART) && (r_k == 4'd7)) begin
                        r_st   <= DONE;
                        r_done <= 1'b1;
                    end else begin
                        r_st        <= SCAN;
                        r_pix_valid <= 1'b1;
                        if ((r_phase == HALF) && (r_k == 4'd8)) begin
                            // Best half-pel point (including this candidate) becomes the quarter-pel centre.
                            r_phase   <= QUART;
                            r_k       <= '0;
                            r_half_dx <= w_nbx;
                            r_half_dy <= w_nby;
                            r_cand_dx <= w_nbx + nb_dx(3'd0);
                            r_cand_dy <= w_nby + nb_dy(3'd0);
                        end else if (r_phase == HALF) begin
                            r_k       <= r_k + 4'd1;
                            r_cand_dx <= nb_dx(r_k[2:0]) <<< 1;
                            r_cand_dy <= nb_dy(r_k[2:0]) <<< 1;
                        end else begin
                            r_k       <= r_k + 4'd1;
                            r_cand_dx <= r_half_dx + nb_dx(w_nb_next);
                            r_cand_dy <= r_half_dy + nb_dy(w_nb_next);
                        end
                    end
                end
                DONE: begin
                    r_st   <= IDLE;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_st <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign best_dx   = r_best_dx;
    assign best_dy   = r_best_dy;
    assign best_sad  = r_best_sad;
    assign cand_dx   = r_cand_dx;
    assign cand_dy   = r_cand_dy;
    assign pix_pos   = {r_row, r_col};
    assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_fme_search_ctrl.sv
// Scoreboard bench for fme_search_ctrl with a 2-cycle behavioural interpolation/abs-diff model.
`timescale 1ns/1ps
module tb_fme_search_ctrl;

    localparam int SAD_W = 12;
    localparam int N     = 64;
    localparam int LAT   = 1140;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic signed [2:0] best_dx;
    logic signed [2:0] best_dy;
    logic [SAD_W-1:0]  best_sad;
    logic signed [2:0] cand_dx;
    logic signed [2:0] cand_dy;
    logic [7:0]        pix_pos;
    logic              pix_valid;
    logic [7:0]        absdiff = 8'd0;
    logic              absdiff_valid = 1'b0;

    fme_search_ctrl #(
        .BLK_W (8),
        .BLK_H (8),
        .PIX_W (8),
        .SAD_W (SAD_W),
        .DP_LAT(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .best_dx      (best_dx),
        .best_dy      (best_dy),
        .best_sad     (best_sad),
        .cand_dx      (cand_dx),
        .cand_dy      (cand_dy),
        .pix_pos      (pix_pos),
        .pix_valid    (pix_valid),
        .absdiff      (absdiff),
        .absdiff_valid(absdiff_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int UX[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int UY[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

    function automatic logic [7:0] model_ad(input int m, input logic signed [2:0] dx,
                                            input logic signed [2:0] dy);
        int ax;
        int ay;
        case (m)
            0:       return 8'd0;
            2:       return 8'd5;
            3:       return 8'd255;
            default: begin
                ax = int'(dx) - 3;
                ay = int'(dy) + 1;
                if (ax < 0) ax = -ax;
                if (ay < 0) ay = -ay;
                return 8'(ax + ay);
            end
        endcase
    endfunction

    logic       v1 = 1'b0;
    logic [7:0] a1 = 8'd0;
    always @(posedge clk) begin
        v1            <= pix_valid;
        a1            <= model_ad(mode, cand_dx, cand_dy);
        absdiff_valid <= v1;
        absdiff       <= a1;
    end

    typedef struct {
        int start_cyc;
        int hx;
        int hy;
        int bx;
        int by;
        int sad;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int exp_cand(input int c, input int h, input int is_y);
        int u;
        if (c == 0) return 0;
        if (c < 9) begin
            u = is_y ? UY[c-1] : UX[c-1];
            return 2 * u;
        end
        if (c < 17) begin
            u = is_y ? UY[c-9] : UX[c-9];
            return h + u;
        end
        return 99;
    endfunction

    int busy_cnt   = 0;
    int pix_cnt    = 0;
    int stream_err = 0;
    int mc;
    int mp;
    int epos;
    int ex;
    int ey;

    // Monitor: checks stream against the front scoreboard entry, pops it on done.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt   = 0;
            pix_cnt    = 0;
            stream_err = 0;
        end else if (sb.size() > 0) begin
            if (busy) busy_cnt++;
            if (pix_valid) begin
                mc   = pix_cnt / N;
                mp   = pix_cnt % N;
                epos = (mp / 8) * 16 + (mp % 8);
                ex   = exp_cand(mc, sb[0].hx, 0);
                ey   = exp_cand(mc, sb[0].hy, 1);
                if (int'(pix_pos) != epos || int'(cand_dx) != ex || int'(cand_dy) != ey)
                    stream_err++;
                pix_cnt++;
            end else if (busy && pix_cnt > 0) begin
                mc = (pix_cnt - 1) / N;
                ex = exp_cand(mc, sb[0].hx, 0);
                ey = exp_cand(mc, sb[0].hy, 1);
                if (int'(cand_dx) != ex || int'(cand_dy) != ey) stream_err++;
            end
            if (done) begin
                chk("done_latency", cyc - sb[0].start_cyc, LAT);
                chk("busy_cycles", busy_cnt, LAT);
                chk("pix_valid_count", pix_cnt, 17 * N);
                chk("stream_mismatches", stream_err, 0);
                chk("best_dx", int'(best_dx), sb[0].bx);
                chk("best_dy", int'(best_dy), sb[0].by);
                chk("best_sad", int'(best_sad), sb[0].sad);
                void'(sb.pop_front());
                busy_cnt   = 0;
                pix_cnt    = 0;
                stream_err = 0;
            end
        end else if (done) begin
            chk("unexpected_done", 1, 0);
        end
    end

    task automatic run_search(input int m, input int hx, input int hy, input int bx,
                              input int by, input int sad, output int st);
        exp_t e;
        mode = m;
        @(posedge clk);
        #1;
        st          = cyc;
        e.start_cyc = cyc;
        e.hx        = hx;
        e.hy        = hy;
        e.bx        = bx;
        e.by        = by;
        e.sad       = sad;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            chk({name, "_timeout"}, 1, 0);
            sb.delete();
        end
        #1;
        chk({name, "_busy_after_done"}, int'(busy), 0);
        chk({name, "_done_after_done"}, int'(done), 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_best_dx"}, int'(best_dx), 0);
        chk({tag, "_best_dy"}, int'(best_dy), 0);
        chk({tag, "_best_sad"}, int'(best_sad), 0);
        chk({tag, "_cand_dx"}, int'(cand_dx), 0);
        chk({tag, "_cand_dy"}, int'(cand_dy), 0);
        chk({tag, "_pix_pos"}, int'(pix_pos), 0);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    endtask

    int st;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        run_search(0, 0, 0, 0, 0, 0, st);
        wait_idle("zero_ad");

        run_search(1, 2, -2, 3, -1, 0, st);
        wait_idle("bowl");

        run_search(2, 0, 0, 0, 0, 320, st);
        wait_idle("const5");

        run_search(3, 0, 0, 0, 0, 4095, st);
        wait_idle("saturate");

        // Stray start pulses mid-scan and on the done cycle must not spawn another search.
        run_search(2, 0, 0, 0, 0, 320, st);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(st + LAT);
        chk("done_on_expected_cycle", int'(done), 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_pending", sb.size(), 0);

        // Reset during the DRAIN of candidate 3, when best and candidate are non-zero.
        run_search(1, 2, -2, 3, -1, 0, st);
        wait_cyc(st + 3 * 67 + 65);
        chk("pre_reset_best_sad", int'(best_sad), 256);
        rst = 1'b1;
        #1;
        chk_reset_vals("midreset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("post_reset_busy", int'(busy), 0);

        run_search(1, 2, -2, 3, -1, 0, st);
        wait_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
